// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use stall, branch flush and operand forwarding control
module pipeline_hazard_ctrl (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_valid,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    input  logic       ex_reg_write,
    input  logic [4:0] mem_rd,
    input  logic       mem_reg_write,
    input  logic       mem_branch,
    input  logic       mem_zero,
    input  logic [4:0] wb_rd,
    input  logic       wb_reg_write,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       exmem_flush,
    output logic       pc_sel,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic [1:0] state,
    output logic [7:0] stall_count,
    output logic [7:0] flush_count
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } hz_state_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    hz_state_t  state_q;
    logic [4:0] ex_rs1_q;
    logic [4:0] ex_rs2_q;
    logic [7:0] stall_count_q;
    logic [7:0] flush_count_q;

    logic taken;
    logic load_use;
    logic flush_evt;
    logic stall_evt;

    // ex_reg_write does not affect load-use detection; only loads create a bubble.
    logic unused_ok;
    assign unused_ok = ex_reg_write;

    assign taken    = mem_branch & mem_zero;
    assign load_use = id_valid & ex_mem_read & (ex_rd != 5'd0) &
                      ((ex_rd == id_rs1) | (ex_rd == id_rs2));

    // A taken branch wins over load-use; FLUSH ignores both for its single cycle.
    always_comb begin
        flush_evt = 1'b0;
        stall_evt = 1'b0;
        if (!reset) begin
            if ((state_q != ST_FLUSH) && taken)
                flush_evt = 1'b1;
            else if ((state_q == ST_RUN) && load_use)
                stall_evt = 1'b1;
        end
    end

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        pc_sel      = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (flush_evt) begin
            pc_sel      = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (stall_evt) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == rs))
            return FWD_MEM;
        else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rs))
            return FWD_WB;
        else
            return FWD_REG;
    endfunction

    always_comb begin
        fwd_a = FWD_REG;
        fwd_b = FWD_REG;
        if (!reset) begin
            fwd_a = fwd_sel(ex_rs1_q);
            fwd_b = fwd_sel(ex_rs2_q);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_RUN;
            ex_rs1_q      <= 5'd0;
            ex_rs2_q      <= 5'd0;
            stall_count_q <= 8'd0;
            flush_count_q <= 8'd0;
        end else begin
            if (idex_flush) begin
                ex_rs1_q <= 5'd0;
                ex_rs2_q <= 5'd0;
            end else begin
                ex_rs1_q <= id_rs1;
                ex_rs2_q <= id_rs2;
            end

            if (flush_evt) begin
                state_q <= ST_FLUSH;
                if (flush_count_q != 8'hFF)
                    flush_count_q <= flush_count_q + 8'd1;
            end else if (stall_evt) begin
                state_q <= ST_STALL;
                if (stall_count_q != 8'hFF)
                    stall_count_q <= stall_count_q + 8'd1;
            end else begin
                state_q <= ST_RUN;
            end
        end
    end

    assign state       = state_q;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_valid, ex_mem_read, ex_reg_write;
    logic       mem_reg_write, mem_branch, mem_zero, wb_reg_write;
    logic       pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pc_sel;
    logic [1:0] fwd_a, fwd_b, state;
    logic [7:0] stall_count, flush_count;

    pipeline_hazard_ctrl dut (
        .clock(clock), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_valid(id_valid),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_branch(mem_branch), .mem_zero(mem_zero),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .pc_sel(pc_sel), .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pc_sel;
        logic [1:0] fwd_a, fwd_b, state;
        logic [7:0] stall_count, flush_count;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference model state
    int         m_state = 0;
    logic [4:0] m_rs1 = 0, m_rs2 = 0;
    int         m_sc = 0, m_fc = 0;
    bit         m_do_flush, m_do_stall;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [1:0] model_fwd(input logic [4:0] rs);
        if (rs == 0) return 2'b00;
        if (mem_reg_write && mem_rd == rs) return 2'b10;
        if (wb_reg_write && wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic push_expected();
        exp_t e;
        bit tk, lu;
        tk = mem_branch && mem_zero;
        lu = id_valid && ex_mem_read && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
        m_do_flush = !reset && tk && m_state != 2;
        m_do_stall = !reset && !m_do_flush && lu && m_state == 0;
        e.pc_write    = !m_do_stall;
        e.ifid_write  = !m_do_stall;
        e.pc_sel      = m_do_flush;
        e.ifid_flush  = m_do_flush;
        e.exmem_flush = m_do_flush;
        e.idex_flush  = m_do_flush || m_do_stall;
        e.fwd_a       = reset ? 2'b00 : model_fwd(m_rs1);
        e.fwd_b       = reset ? 2'b00 : model_fwd(m_rs2);
        e.state       = 2'(m_state);
        e.stall_count = 8'(m_sc);
        e.flush_count = 8'(m_fc);
        exp_q.push_back(e);
    endtask

    task automatic compare_output();
        exp_t e;
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 8'd1, 8'd0);
            return;
        end
        e = exp_q.pop_front();
        check_eq("pc_write", {7'd0, pc_write}, {7'd0, e.pc_write});
        check_eq("ifid_write", {7'd0, ifid_write}, {7'd0, e.ifid_write});
        check_eq("ifid_flush", {7'd0, ifid_flush}, {7'd0, e.ifid_flush});
        check_eq("idex_flush", {7'd0, idex_flush}, {7'd0, e.idex_flush});
        check_eq("exmem_flush", {7'd0, exmem_flush}, {7'd0, e.exmem_flush});
        check_eq("pc_sel", {7'd0, pc_sel}, {7'd0, e.pc_sel});
        check_eq("fwd_a", {6'd0, fwd_a}, {6'd0, e.fwd_a});
        check_eq("fwd_b", {6'd0, fwd_b}, {6'd0, e.fwd_b});
        check_eq("state", {6'd0, state}, {6'd0, e.state});
        check_eq("stall_count", stall_count, e.stall_count);
        check_eq("flush_count", flush_count, e.flush_count);
    endtask

    task automatic advance_model();
        if (reset) begin
            m_state = 0; m_rs1 = 0; m_rs2 = 0; m_sc = 0; m_fc = 0;
        end else begin
            if (m_do_flush || m_do_stall) begin
                m_rs1 = 0; m_rs2 = 0;
            end else begin
                m_rs1 = id_rs1; m_rs2 = id_rs2;
            end
            if (m_do_flush) begin
                m_state = 2;
                if (m_fc < 255) m_fc++;
            end else if (m_do_stall) begin
                m_state = 1;
                if (m_sc < 255) m_sc++;
            end else begin
                m_state = 0;
            end
        end
    endtask

    // Inputs are already driven; check this cycle, then clock it in.
    task automatic step();
        push_expected();
        @(negedge clock);
        compare_output();
        @(posedge clock);
        advance_model();
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0;
        id_rs1 = 0; id_rs2 = 0; id_valid = 0;
        ex_rd = 0; ex_mem_read = 0; ex_reg_write = 0;
        mem_rd = 0; mem_reg_write = 0; mem_branch = 0; mem_zero = 0;
        wb_rd = 0; wb_reg_write = 0;
    endtask

    task automatic set_load_use();
        id_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5; id_rs2 = 5; id_rs1 = 7;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        @(posedge clock);
        #1;

        // reset with hazards present: outputs must stay at defaults
        mem_branch = 1; mem_zero = 1; set_load_use();
        mem_reg_write = 1; mem_rd = 0; wb_reg_write = 1; wb_rd = 0;
        step(); step();
        idle_inputs(); step();

        // load-use: one bubble, second cycle ignored in STALL
        set_load_use(); step(); step();
        idle_inputs(); step();
        check_eq("stall_count_after_lu", stall_count, 8'd1);

        // taken branch held two cycles: FLUSH ignores the second
        mem_branch = 1; mem_zero = 1; step(); step();
        idle_inputs(); step();
        check_eq("flush_count_after_br", flush_count, 8'd1);

        // simultaneous taken and load-use
        set_load_use(); mem_branch = 1; mem_zero = 1;
        push_expected();
        @(negedge clock);
        check_eq("sim_pc_write", {7'd0, pc_write}, 8'd1);
        compare_output();
        @(posedge clock); advance_model(); #1;
        check_eq("sim_state", {6'd0, state}, 8'h02);
        check_eq("sim_stall_count", stall_count, 8'd1);
        idle_inputs(); step();

        // taken while in STALL
        set_load_use(); step();
        idle_inputs(); mem_branch = 1; mem_zero = 1; step();
        idle_inputs(); step(); step();

        // forwarding priority on ex_rs1 = 3
        id_rs1 = 3; id_rs2 = 3; step();
        mem_rd = 3; wb_rd = 3; mem_reg_write = 1; wb_reg_write = 1;
        push_expected();
        @(negedge clock);
        check_eq("fwd_mem_prio", {6'd0, fwd_a}, 8'h02);
        compare_output();
        @(posedge clock); advance_model(); #1;
        mem_rd = 0;
        push_expected();
        @(negedge clock);
        check_eq("fwd_wb", {6'd0, fwd_a}, 8'h01);
        compare_output();
        @(posedge clock); advance_model(); #1;
        id_rs1 = 0; id_rs2 = 0; step();
        mem_rd = 0; wb_rd = 0;
        push_expected();
        @(negedge clock);
        check_eq("fwd_x0", {6'd0, fwd_a}, 8'h00);
        compare_output();
        @(posedge clock); advance_model(); #1;

        // random traffic over small register numbers to provoke matches
        for (int i = 0; i < 300; i++) begin
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            id_valid = 1'($urandom); ex_rd = 5'($urandom_range(0, 3));
            ex_mem_read = 1'($urandom); ex_reg_write = 1'($urandom);
            mem_rd = 5'($urandom_range(0, 3)); mem_reg_write = 1'($urandom);
            mem_branch = ($urandom_range(0, 3) == 0); mem_zero = 1'($urandom);
            wb_rd = 5'($urandom_range(0, 3)); wb_reg_write = 1'($urandom);
            step();
        end

        // counter saturation: 260 load-use entries (RUN/STALL alternation)
        reset = 1; idle_inputs(); reset = 1; step();
        idle_inputs(); set_load_use();
        for (int i = 0; i < 520; i++) step();
        idle_inputs(); step();
        check_eq("stall_count_sat", stall_count, 8'd255);

        // reset while in STALL aborts it
        set_load_use(); step();
        check_eq("in_stall", {6'd0, state}, 8'h01);
        reset = 1; step();
        idle_inputs(); step();
        check_eq("reset_state", {6'd0, state}, 8'h00);
        check_eq("reset_stall_count", stall_count, 8'd0);
        check_eq("reset_flush_count", flush_count, 8'd0);

        check_eq("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have port clock, input, 1 bit: rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have ports id_rs1 and id_rs2, input, 5 bits each: source registers of the instruction in ID.
REQ-004 SHALL have port id_valid, input, 1 bit: ID holds a real instruction.
REQ-005 SHALL have ports ex_rd (5 bits), ex_mem_read (1 bit) and ex_reg_write (1 bit), all input: destination and controls of the instruction in EXE.
REQ-006 SHALL have ports mem_rd (5 bits), mem_reg_write (1 bit), mem_branch (1 bit) and mem_zero (1 bit), all input: registered EXE outputs of the instruction in MEM.
REQ-007 SHALL have ports wb_rd (5 bits) and wb_reg_write (1 bit), both input: destination and write enable of the instruction in WB.
REQ-008 SHALL have ports pc_write and ifid_write, output, 1 bit each: PC and IF/ID register update enables.
REQ-009 SHALL have ports ifid_flush, idex_flush and exmem_flush, output, 1 bit each: force the named pipeline register to a bubble.
REQ-010 SHALL have port pc_sel, output, 1 bit: 1 selects the branch target (PC_jump) as next PC.
REQ-011 SHALL have ports fwd_a and fwd_b, output, 2 bits each: EXE operand select; 00 = register file, 10 = MEM ALU_result, 01 = WB write-back data.
REQ-012 SHALL have port state, output, 2 bits: 00 = RUN, 01 = STALL, 10 = FLUSH.
REQ-013 SHALL have ports stall_count and flush_count, output, 8 bits each: saturating event counters.

Function
REQ-014 SHALL define taken = mem_branch & mem_zero.
REQ-015 SHALL define load_use = id_valid & ex_mem_read & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2).
REQ-016 SHALL, in RUN or STALL, on taken in the same cycle: assert pc_sel, ifid_flush, idex_flush and exmem_flush (all combinational), and enter FLUSH next edge.
REQ-017 SHALL, in RUN with load_use and no taken in the same cycle: assert pc_write=0, ifid_write=0 and idex_flush=1, and enter STALL next edge.
REQ-018 SHALL give taken priority over load_use when both are true in the same cycle; only flush_count increments.
REQ-019 SHALL ignore load_use while in STALL, return to RUN after exactly 1 cycle unless taken, and limit each load-use event to exactly one bubble.
REQ-020 SHALL ignore both taken and load_use while in FLUSH and return to RUN after exactly 1 cycle.
REQ-021 SHALL hold pc_write=1, ifid_write=1, pc_sel=0 and all flushes at 0 whenever REQ-016/017 do not apply.
REQ-022 SHALL keep internal ex_rs1/ex_rs2 registers: load id_rs1/id_rs2 each edge; load 0 when idex_flush is asserted.
REQ-023 SHALL set fwd_a=10 if mem_reg_write & mem_rd!=0 & mem_rd==ex_rs1; else 01 if wb_reg_write & wb_rd!=0 & wb_rd==ex_rs1; else 00.
REQ-024 SHALL compute fwd_b in the same way against ex_rs2; MEM takes priority over WB.
REQ-025 SHALL compute fwd_a/fwd_b combinationally from registered ex_rs and the current mem/wb inputs.
REQ-026 SHALL increment stall_count on each REQ-017 entry and flush_count on each REQ-016 event, with both counters saturating at 255.
REQ-027 SHALL treat register x0 as never hazardous and never forwarded.

Reset
REQ-028 SHALL, while reset=1 at an edge, set state=RUN, ex_rs1=ex_rs2=0 and both counters to 0.
REQ-029 SHALL, during a reset cycle, drive pc_write=1, ifid_write=1, pc_sel=0, all flushes 0 and fwd_a=fwd_b=00, regardless of other inputs.
REQ-030 SHALL let reset asserted during STALL or FLUSH abort that state, with RUN on the next cycle.

Verification
REQ-031 SHALL cover load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_valid=1 -> pc_write=0, ifid_write=0, idex_flush=1 for 1 cycle; state 01 then 00; stall_count=1.
REQ-032 SHALL cover taken branch: mem_branch=1, mem_zero=1 -> pc_sel and all three flushes =1 for 1 cycle; state 10 then 00; flush_count=1.
REQ-033 SHALL cover simultaneous events: taken and load_use in the same cycle -> flush only, pc_write=1, stall_count unchanged, state=10.
REQ-034 SHALL cover forwarding priority: ex_rs1=3, mem_rd=3, wb_rd=3, both reg_write=1 -> fwd_a=10; with mem_rd=0 -> fwd_a=01; with rd=x0 -> fwd_a=00.
REQ-035 SHALL cover saturation and reset: 260 load-use events -> stall_count=255; reset in STALL -> state=00 and counters=0 next cycle.
